// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_OP_*    : 3-bit operation encodings. Bit 0 set means unsigned.
//   - mdu_state_e : control FSM states.
//   - abs_w()     : conditional two's-complement negate at MDU_MAX_W bits.
//                   Callers zero-extend narrower operands and truncate the result.
//   - neg_2w()    : two's-complement negate at MDU_MAX_2W bits, used the same way.
// WIDTH of any user module must not exceed MDU_MAX_W.
package mdu_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_MADD  = 3'd2;
  localparam logic [2:0] MDU_OP_MADDU = 3'd3;
  localparam logic [2:0] MDU_OP_MSUB  = 3'd4;
  localparam logic [2:0] MDU_OP_MSUBU = 3'd5;
  localparam logic [2:0] MDU_OP_DIV   = 3'd6;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd7;

  localparam int MDU_MAX_W  = 64;
  localparam int MDU_MAX_2W = 2 * MDU_MAX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Negates x when neg is set. Passing the sign bit as neg yields the magnitude.
  function automatic logic [MDU_MAX_W-1:0] abs_w(input logic [MDU_MAX_W-1:0] x,
                                                input logic                 neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [MDU_MAX_2W-1:0] neg_2w(input logic [MDU_MAX_2W-1:0] x);
    return -x;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider datapath, one quotient bit per step.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture dividend, clear partial remainder and counter
//   step            perform one restoring iteration
//   dividend        unsigned dividend (sampled on load)
//   divisor         unsigned divisor (must be held stable while stepping)
//   quotient        quotient shift register contents
//   remainder       partial remainder
//   done            high on the step that produces the final quotient bit
module mdu_div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // The dividend shifts out of the top of quo_q into the remainder while
  // quotient bits shift in at the bottom. When the trial subtraction succeeds
  // the true difference is below divisor, so WIDTH bits are enough for it.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    diff    = shifted[WIDTH-1:0] - divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= ge ? diff : shifted[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], ge};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU and returns {HI,LO}.
// Build option: define MDU_MUL_ITER_EN for a radix-2 shift-add multiplier
// (WIDTH cycles); otherwise the multiply is one cycle of array multiply.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         request, sampled only in IDLE
//   op_i            MDU_OP_* encoding
//   opa_i, opb_i    multiplicand/dividend, multiplier/divisor
//   acc_i           {HI,LO} accumulator for MADD/MSUB, sampled with start_i
//   annul_i         flush; aborts the operation in any state
//   busy_o          operation in flight (MUL or DIV state)
//   ready_o         one-cycle pulse, result_o valid
//   result_o        {HI,LO}; divide gives {remainder, quotient}
//   div_by_zero_o   qualifies ready_o for a divide with zero divisor
//   dbg_state_o     current FSM state
// Handshake: a request is taken when start_i=1 in IDLE with annul_i=0; there
// is no queuing. The result is presented for exactly one cycle with ready_o=1
// (the DONE state), start_i must be low in that cycle, and the next request
// may be issued the cycle after.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o,
  output mdu_state_e         dbg_state_o
);

  mdu_state_e         state_q, state_d;
  logic [2:0]         op_q;
  logic               sa_q, sb_q, dz_q;
  logic [WIDTH-1:0]   a_mag_q, b_mag_q;
  logic [2*WIDTH-1:0] acc_q, prod_q, result_q;

  logic               signed_in, is_div_in, div_zero_in, accept;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [WIDTH-1:0]   quotient, remainder;
  logic               div_done, mul_last;
  logic               sgn_op, neg_res;
  logic [2*WIDTH-1:0] prod_s, final_result;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Operands become magnitudes at latch time; the signs are reapplied in DONE.
  always_comb begin
    signed_in   = ~op_i[0];
    is_div_in   = op_i[2] & op_i[1];
    div_zero_in = is_div_in && (opb_i == '0);
    accept      = (state_q == IDLE) && start_i && !annul_i;
    a_mag_in    = WIDTH'(abs_w(MDU_MAX_W'(opa_i), signed_in & opa_i[WIDTH-1]));
    b_mag_in    = WIDTH'(abs_w(MDU_MAX_W'(opb_i), signed_in & opb_i[WIDTH-1]));
  end

  mdu_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state_q == DIV),
    .dividend (a_mag_in),
    .divisor  (b_mag_q),
    .quotient (quotient),
    .remainder(remainder),
    .done     (div_done)
  );

`ifdef MDU_MUL_ITER_EN
  logic [CNT_W-1:0] mul_cnt_q;
  logic [WIDTH:0]   mul_sum;

  // prod_q starts as {0, multiplier}; each step adds the multiplicand into
  // the upper half when the low bit is set, then shifts the pair right.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    mul_last = (mul_cnt_q == CNT_W'(WIDTH - 1));
  end
`else
  assign mul_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_div_in ? (div_zero_in ? DONE : DIV) : MUL;
      MUL:  if (mul_last) state_d = DONE;
      DIV:  if (div_done) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (annul_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
`ifdef MDU_MUL_ITER_EN
      mul_cnt_q <= '0;
`endif
    end else begin
      if (accept) begin
        op_q    <= op_i;
        sa_q    <= signed_in & opa_i[WIDTH-1];
        sb_q    <= signed_in & opb_i[WIDTH-1];
        dz_q    <= div_zero_in;
        a_mag_q <= a_mag_in;
        b_mag_q <= b_mag_in;
        acc_q   <= acc_i;
`ifdef MDU_MUL_ITER_EN
        prod_q    <= (2*WIDTH)'(b_mag_in);
        mul_cnt_q <= '0;
`endif
      end
      if (state_q == MUL) begin
`ifdef MDU_MUL_ITER_EN
        prod_q    <= {mul_sum, prod_q[WIDTH-1:1]};
        mul_cnt_q <= mul_cnt_q + 1'b1;
`else
        prod_q <= (2*WIDTH)'(a_mag_q) * (2*WIDTH)'(b_mag_q);
`endif
      end
      if (ready_o) result_q <= final_result;
    end
  end

  // Sign fix-up and accumulate. Quotient sign is sa^sb, remainder follows the
  // dividend. MIN/-1 needs no special case: |MIN| as unsigned divided by 1
  // gives 2^(WIDTH-1), which negates back to MIN.
  always_comb begin
    sgn_op  = ~op_q[0];
    neg_res = sgn_op & (sa_q ^ sb_q);
    prod_s  = neg_res ? (2*WIDTH)'(neg_2w(MDU_MAX_2W'(prod_q))) : prod_q;
    quo_s   = WIDTH'(abs_w(MDU_MAX_W'(quotient), neg_res));
    rem_s   = WIDTH'(abs_w(MDU_MAX_W'(remainder), sgn_op & sa_q));
    case (op_q)
      MDU_OP_MULT, MDU_OP_MULTU: final_result = prod_s;
      MDU_OP_MADD, MDU_OP_MADDU: final_result = acc_q + prod_s;
      MDU_OP_MSUB, MDU_OP_MSUBU: final_result = acc_q - prod_s;
      default:                   final_result = dz_q ? '0 : {rem_s, quo_s};
    endcase
  end

  assign ready_o       = (state_q == DONE) && !annul_i;
  assign busy_o        = (state_q == MUL) || (state_q == DIV);
  assign result_o      = ready_o ? final_result : result_q;
  assign div_by_zero_o = ready_o && dz_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_MUL_ITER_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] acc;
  logic           annul;
  logic           busy_o, ready_o, div_by_zero_o;
  logic [2*W-1:0] result_o;
  mdu_state_e     dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .op_i         (op),
    .opa_i        (opa),
    .opb_i        (opb),
    .acc_i        (acc),
    .annul_i      (annul),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .result_o     (result_o),
    .div_by_zero_o(div_by_zero_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [2*W-1:0] ac);
    longint          sp;
    longint unsigned up;
    int              qa, qb, q, r;
    logic [W-1:0]    uq, ur;
    sp = longint'(int'(a)) * longint'(int'(b));
    up = longint'({32'd0, a}) * longint'({32'd0, b});
    case (o)
      MDU_OP_MULT:  return sp;
      MDU_OP_MULTU: return up;
      MDU_OP_MADD:  return ac + sp;
      MDU_OP_MADDU: return ac + up;
      MDU_OP_MSUB:  return ac - sp;
      MDU_OP_MSUBU: return ac - up;
      MDU_OP_DIV: begin
        if (b == 0) return '0;
        qa = int'(a);
        qb = int'(b);
        if (a == 32'h8000_0000 && qb == -1) begin
          q = qa;
          r = 0;
        end else begin
          q = qa / qb;
          r = qa % qb;
        end
        return {r, q};
      end
      default: begin
        if (b == 0) return '0;
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [W-1:0] b);
    if (o == MDU_OP_DIV || o == MDU_OP_DIVU) return (b == 0) ? 1 : DIV_LAT;
    return MUL_LAT;
  endfunction

  function automatic logic ref_dz(input logic [2:0] o, input logic [W-1:0] b);
    return (o == MDU_OP_DIV || o == MDU_OP_DIVU) && (b == 0);
  endfunction

  // ---------------- driver ----------------
  // Issues one request and watches for ready_o under a cycle budget; lat=-1 on timeout.
  // busy_err counts cycles where busy_o was low before ready_o, or high with it.
  task automatic drive_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] ac, output int lat, output logic [2*W-1:0] res,
                          output logic dz, output int busy_err);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; acc = ac;
    lat = -1; res = '0; dz = 1'b0; busy_err = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      opa = $urandom; opb = $urandom; acc = {$urandom, $urandom};
      if (ready_o) begin
        lat = k; res = result_o; dz = div_by_zero_o;
        if (busy_o) busy_err++;
        break;
      end
      if (!busy_o) busy_err++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0; opa = '0; opb = '0; acc = '0;
    repeat (3) @(negedge clk);
    total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state_o, IDLE); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    total++; if (result_o !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    total++; if (div_by_zero_o !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_by_zero_o); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]     d_op[6]  = '{MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_MSUB, MDU_OP_MADD};
    logic [W-1:0]   d_a[6]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd3, 32'd1};
    logic [W-1:0]   d_b[6]   = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd4, 32'd1};
    logic [2*W-1:0] d_acc[6] = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [2*W-1:0] d_exp[6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd88, 64'd0};
    int             d_lat[6] = '{MUL_LAT, MUL_LAT, DIV_LAT, 1, MUL_LAT, MUL_LAT};
    logic           d_dz[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, berr;
    logic [2*W-1:0] res;
    logic dz;
    for (int i = 0; i < 6; i++) begin
      drive_op(d_op[i], d_a[i], d_b[i], d_acc[i], lat, res, dz, berr);
      total++; if (lat !== d_lat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, d_lat[i]); end
      total++; if (res !== d_exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, d_exp[i]); end
      total++; if (dz !== d_dz[i]) begin bad++; $display("FAIL dir%0d_dz got=%b want=%b", i, dz, d_dz[i]); end
      total++; if (berr !== 0) begin bad++; $display("FAIL dir%0d_busy bad_cycles=%0d want=0", i, berr); end
    end
    // result_o holds after the ready pulse
    @(negedge clk);
    total++; if (result_o !== d_exp[5]) begin bad++; $display("FAIL hold_result got=%h want=%h", result_o, d_exp[5]); end
  endtask

  // Back-to-back random requests, each issued the cycle after the previous DONE.
  task automatic test_back_to_back();
    logic [2:0] o;
    logic [W-1:0] a, b;
    logic [2*W-1:0] ac, res, e;
    int lat, berr, sel;
    logic dz;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; ac = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'h8000_0000;
      exp_q.push_back(ref_result(o, a, b, ac));
      drive_op(o, a, b, ac, lat, res, dz, berr);
      e = exp_q.pop_front();
      total++; if (res !== e) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, res, e); end
      total++; if (lat !== ref_latency(o, b)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, ref_latency(o, b)); end
      total++; if (dz !== ref_dz(o, b)) begin bad++; $display("FAIL rnd%0d_dz got=%b want=%b", i, dz, ref_dz(o, b)); end
      total++; if (berr !== 0) begin bad++; $display("FAIL rnd%0d_busy bad_cycles=%0d want=0", i, berr); end
    end
  endtask

  task automatic test_annul();
    logic [2*W-1:0] prev, res;
    int lat, berr, seen;
    logic dz;
    drive_op(MDU_OP_MULTU, 32'd7, 32'd9, '0, lat, prev, dz, berr);
    total++; if (prev !== 64'd63) begin bad++; $display("FAIL annul_pre got=%h want=%h", prev, 64'd63); end
    // DIV started at T, annul driven during T+10
    @(negedge clk);
    start = 1'b1; op = MDU_OP_DIV; opa = 32'd1000; opb = 32'd3;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready_o) seen++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL annul_state got=%0d want=%0d", dbg_state_o, IDLE); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL annul_busy got=%b want=0", busy_o); end
    total++; if (result_o !== prev) begin bad++; $display("FAIL annul_result got=%h want=%h", result_o, prev); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL annul_noready pulses=%0d want=0", seen); end
    drive_op(MDU_OP_DIVU, 32'd9, 32'd4, '0, lat, res, dz, berr);
    total++; if (res !== {32'd1, 32'd2}) begin bad++; $display("FAIL annul_next got=%h want=%h", res, {32'd1, 32'd2}); end
    // annul together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; annul = 1'b1; op = MDU_OP_MULT; opa = 32'd2; opb = 32'd2;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    total++; if (dbg_state_o !== IDLE || busy_o !== 1'b0) begin bad++; $display("FAIL annul_start state=%0d busy=%b want IDLE/0", dbg_state_o, busy_o); end
  endtask

  task automatic test_ignore_start();
    int lat, seen;
    logic [2*W-1:0] res;
    @(negedge clk);
    start = 1'b1; op = MDU_OP_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    opa = 32'd50; opb = 32'd5; op = MDU_OP_MULTU;   // start still high: must be ignored
    lat = -1; res = '0;
    for (int k = 2; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready_o) begin lat = k; res = result_o; break; end
    end
    total++; if (lat !== DIV_LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, DIV_LAT); end
    total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL ignore_result got=%h want=%h", res, {32'd2, 32'd14}); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy_o || ready_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL ignore_noqueue cycles=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = MDU_OP_DIV; opa = 32'hFFFF_FF00; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL rstmid_state got=%0d want=%0d", dbg_state_o, IDLE); end
    total++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin bad++; $display("FAIL rstmid_flags busy=%b ready=%b want=0/0", busy_o, ready_o); end
    total++; if (result_o !== '0) begin bad++; $display("FAIL rstmid_result got=%h want=0", result_o); end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_annul();
    test_ignore_start();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
